// File: rtl/sprite_compositor_pkg.sv
// Display-wide constants, colours and the player sprite bitmap.
// Shared by the background scanner, the sprite compositor and the VGA top level.
package sprite_compositor_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOR_W  = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  localparam int SPR_W     = 16;
  localparam int SPR_H     = 16;
  localparam int SPR_XB    = $clog2(SPR_W);
  localparam int SPR_YB    = $clog2(SPR_H);
  localparam int ROM_AW    = SPR_XB + SPR_YB;
  localparam int ROM_DEPTH = SPR_W * SPR_H;

  typedef logic [COLOR_W-1:0] colour_t;

  localparam colour_t TRANSP    = 3'b101;
  localparam colour_t COL_BLACK = 3'b000;
  localparam colour_t COL_GREEN = 3'b010;
  localparam colour_t COL_RED   = 3'b100;
  localparam colour_t COL_SKIN  = 3'b110;
  localparam colour_t COL_WHITE = 3'b111;

  // One beat travelling from the compare stage to the colour-select stage.
  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           hit;
  } beat_t;

  // Mushroom bitmap, leftmost character is column 0.
  // R red, W white, K black, S skin, '.' transparent.
  localparam logic [8*SPR_W-1:0] SPRITE_ART [SPR_H] = '{
    "......RRRR......",
    "....RRWWRRRR....",
    "....RWWWRRRRR...",
    "..RRWWWRRRWWRR..",
    ".RRRRRRRWWWWRRR.",
    ".WWRRRRRRWWWWRR.",
    "WWWWRRRRRRRRRWWW",
    "WWWRRRRRRRRRRRWW",
    "RRRRRRRRRRRRRRRR",
    "..KKSSSSSSSSKK..",
    "...SSSKSSKSSS...",
    "...SSSKSSKSSS...",
    "...SSSSSSSSSS...",
    "....SSSSSSSS....",
    ".....SSSSSS.....",
    "................"
  };

  // Decodes one bitmap character into a colour; address is {row, column}.
  function automatic colour_t art_texel(input logic [ROM_AW-1:0] addr);
    logic [SPR_YB-1:0] row;
    logic [SPR_XB-1:0] col;
    logic [7:0]        ch;
    int                base;
    row  = addr[ROM_AW-1 -: SPR_YB];
    col  = addr[SPR_XB-1:0];
    base = 8 * (SPR_W - 1 - int'(col));
    ch   = SPRITE_ART[row][base +: 8];
    case (ch)
      "R":     art_texel = COL_RED;
      "W":     art_texel = COL_WHITE;
      "K":     art_texel = COL_BLACK;
      "S":     art_texel = COL_SKIN;
      default: art_texel = TRANSP;
    endcase
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream from the background scanner, sprite controls from game logic,
// and the plot stream towards the VGA adapter.
interface sprite_compositor_if;
  import sprite_compositor_pkg::*;

  logic           in_valid;
  logic [X_W-1:0] in_x;
  logic [Y_W-1:0] in_y;
  colour_t        in_color;

  logic           frame_start;
  logic [X_W-1:0] sprite_x;
  logic [Y_W-1:0] sprite_y;
  logic           sprite_en;

  logic           out_plot;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  colour_t        out_colour;
  logic           frame_done;

  modport master (
    output in_valid, in_x, in_y, in_color,
    output frame_start, sprite_x, sprite_y, sprite_en,
    input  out_plot, out_x, out_y, out_colour, frame_done
  );

  modport slave (
    input  in_valid, in_x, in_y, in_color,
    input  frame_start, sprite_x, sprite_y, sprite_en,
    output out_plot, out_x, out_y, out_colour, frame_done
  );

endinterface

// File: rtl/sprite_compositor_rom.sv
// Player sprite ROM, one colour per texel, registered read (one cycle latency)
// so its data lines up with the background RAM colour.
module sprite_rom
  import sprite_compositor_pkg::*;
#(
  parameter int AW = ROM_AW
) (
  input  logic          CLOCK_50,
  input  logic [AW-1:0] addr,
  output colour_t       q
);

  localparam int DEPTH = 1 << AW;

  colour_t mem [DEPTH];
  colour_t q_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_texel
      assign mem[gi] = art_texel(AW'(gi));
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    q_reg <= mem[addr];
  end

  assign q = q_reg;

endmodule

// File: rtl/sprite_compositor.sv
// Overlays the 16x16 player sprite on the background pixel stream.
// Two-stage pipeline: position compare + ROM address, then colour select.
module sprite_compositor
  import sprite_compositor_pkg::*;
(
  input logic            CLOCK_50,
  input logic            resetn,
  sprite_compositor_if.slave bus
);

  logic [X_W-1:0] lat_x_reg;
  logic [Y_W-1:0] lat_y_reg;
  logic           lat_en_reg;

  logic [X_W-1:0] eff_x;
  logic [Y_W-1:0] eff_y;
  logic           eff_en;

  logic [X_W:0]   dx;
  logic [Y_W:0]   dy;
  logic           hit;
  logic [ROM_AW-1:0] rom_addr;
  colour_t        spr_q;

  beat_t          s1_reg;
  beat_t          s1_next;

  colour_t        colour_next;
  logic           frame_done_next;

  logic           out_plot_reg;
  logic [X_W-1:0] out_x_reg;
  logic [Y_W-1:0] out_y_reg;
  colour_t        out_colour_reg;
  logic           frame_done_reg;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      lat_x_reg  <= '0;
      lat_y_reg  <= '0;
      lat_en_reg <= 1'b0;
    end else if (bus.frame_start) begin
      lat_x_reg  <= bus.sprite_x;
      lat_y_reg  <= bus.sprite_y;
      lat_en_reg <= bus.sprite_en;
    end
  end

  // A pixel arriving together with frame_start already belongs to the new frame.
  always_comb begin
    eff_x  = lat_x_reg;
    eff_y  = lat_y_reg;
    eff_en = lat_en_reg;
    if (bus.frame_start) begin
      eff_x  = bus.sprite_x;
      eff_y  = bus.sprite_y;
      eff_en = bus.sprite_en;
    end
  end

  // Extra top bit catches pixels left of / above the sprite; no screen-size wrap.
  assign dx = {1'b0, bus.in_x} - {1'b0, eff_x};
  assign dy = {1'b0, bus.in_y} - {1'b0, eff_y};

  assign hit = eff_en
             & ~dx[X_W] & ~(|dx[X_W-1:SPR_XB])
             & ~dy[Y_W] & ~(|dy[Y_W-1:SPR_YB]);

  assign rom_addr = {dy[SPR_YB-1:0], dx[SPR_XB-1:0]};

  sprite_rom #(
    .AW (ROM_AW)
  ) u_sprite_rom (
    .CLOCK_50 (CLOCK_50),
    .addr     (rom_addr),
    .q        (spr_q)
  );

  always_comb begin
    s1_next.valid = bus.in_valid;
    s1_next.x     = bus.in_x;
    s1_next.y     = bus.in_y;
    s1_next.hit   = hit;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      s1_reg <= '0;
    end else begin
      s1_reg <= s1_next;
    end
  end

  // Background RAM colour and sprite texel both arrive this cycle.
  always_comb begin
    colour_next = bus.in_color;
    if (s1_reg.hit && (spr_q != TRANSP)) begin
      colour_next = spr_q;
    end
    frame_done_next = s1_reg.valid
                    && (s1_reg.x == X_W'(SCREEN_W - 1))
                    && (s1_reg.y == Y_W'(SCREEN_H - 1));
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      out_plot_reg   <= 1'b0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      out_colour_reg <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      out_plot_reg   <= s1_reg.valid;
      frame_done_reg <= frame_done_next;
      if (s1_reg.valid) begin
        out_x_reg      <= s1_reg.x;
        out_y_reg      <= s1_reg.y;
        out_colour_reg <= colour_next;
      end
    end
  end

  assign bus.out_plot   = out_plot_reg;
  assign bus.out_x      = out_x_reg;
  assign bus.out_y      = out_y_reg;
  assign bus.out_colour = out_colour_reg;
  assign bus.frame_done = frame_done_reg;

endmodule
